// File: rtl/msftdvip_apb_dec_pkg.sv
// Shared types for the parametrised APB decoder: FSM states, error codes and sizing helpers.
// Optional watchdog build macro: MSFTDVIP_APB_DEC_TIMEOUT_EN.
package msftdvip_apb_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    DEFRSP = 2'd2,
    TOUT   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_SUB     = 2'd3
  } err_code_t;

  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msftdvip_apb_dec_addr_match.sv
// Combinational base/mask priority matcher; zero latency, lowest matching index wins on overlap.
module msftdvip_apb_dec_addr_match
  import msftdvip_apb_dec_pkg::*;
#(
  parameter int NUM_SUB = 10,
  parameter int AW      = 32,
  parameter int IW      = 4,
  parameter logic [NUM_SUB*AW-1:0] SUB_BASE = '0,
  parameter logic [NUM_SUB*AW-1:0] SUB_MASK = '0
) (
  input  logic [AW-1:0] i_addr,
  output logic          o_hit_any,
  output logic [IW-1:0] o_idx
);

  // Scan downward so the last assignment is the lowest matching index.
  always_comb begin
    o_hit_any = 1'b0;
    o_idx     = '0;
    for (int k = NUM_SUB - 1; k >= 0; k--) begin
      if ((i_addr & SUB_MASK[k*AW +: AW]) == (SUB_BASE[k*AW +: AW] & SUB_MASK[k*AW +: AW])) begin
        o_hit_any = 1'b1;
        o_idx     = IW'(k);
      end
    end
  end

endmodule

// File: rtl/msftdvip_apb_decoder_n.sv
// APB 1:NUM_SUB decoder: setup-phase selects are combinational, responses pass through with no added latency;
// the manager stalls while the selected subordinate holds PREADY low (watchdog via MSFTDVIP_APB_DEC_TIMEOUT_EN).
module msftdvip_apb_decoder_n
  import msftdvip_apb_dec_pkg::*;
#(
  parameter int NUM_SUB        = 10,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter logic [NUM_SUB*APB_ADDR_WIDTH-1:0] SUB_BASE = {NUM_SUB{32'h0}},
  parameter logic [NUM_SUB*APB_ADDR_WIDTH-1:0] SUB_MASK = {NUM_SUB{32'hFFFF_F000}},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                psel_mgr_i,
  input  logic                                penable_mgr_i,
  input  logic [APB_ADDR_WIDTH-1:0]           paddr_mgr_i,
  input  logic [APB_DATA_WIDTH-1:0]           pwdata_mgr_i,
  input  logic                                pwrite_mgr_i,
  input  logic [APB_DATA_WIDTH/8-1:0]         pstrb_mgr_i,
  output logic [APB_DATA_WIDTH-1:0]           prdata_mgr_o,
  output logic                                pready_mgr_o,
  output logic                                psuberr_mgr_o,
  output logic [NUM_SUB-1:0]                  psel_sub_o,
  output logic                                penable_sub_o,
  output logic [APB_ADDR_WIDTH-1:0]           paddr_sub_o,
  output logic [APB_DATA_WIDTH-1:0]           pwdata_sub_o,
  output logic                                pwrite_sub_o,
  output logic [APB_DATA_WIDTH/8-1:0]         pstrb_sub_o,
  input  logic [NUM_SUB*APB_DATA_WIDTH-1:0]   prdata_sub_i,
  input  logic [NUM_SUB-1:0]                  pready_sub_i,
  input  logic [NUM_SUB-1:0]                  psuberr_sub_i,
  output logic                                err_valid_o,
  output logic [1:0]                          err_code_o,
  output logic [APB_ADDR_WIDTH-1:0]           err_addr_o,
  input  logic                                err_clr_i
);

  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int IW = idx_width(NUM_SUB);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [AW-1:0]   r_addr;
  logic            r_err_valid;
  err_code_t       r_err_code;
  logic [AW-1:0]   r_err_addr;

  logic            w_hit_any;
  logic [IW-1:0]   w_idx;
  logic            w_sub_rdy;
  logic            w_sub_err;
  logic [DW-1:0]   w_sub_rdata;
  logic            w_tout_hit;
  err_code_t       w_err_evt;

  msftdvip_apb_dec_addr_match #(
    .NUM_SUB  (NUM_SUB),
    .AW       (AW),
    .IW       (IW),
    .SUB_BASE (SUB_BASE),
    .SUB_MASK (SUB_MASK)
  ) u_match (
    .i_addr    (paddr_mgr_i),
    .o_hit_any (w_hit_any),
    .o_idx     (w_idx)
  );

  assign penable_sub_o = penable_mgr_i;
  assign paddr_sub_o   = paddr_mgr_i;
  assign pwdata_sub_o  = pwdata_mgr_i;
  assign pwrite_sub_o  = pwrite_mgr_i;
  assign pstrb_sub_o   = pstrb_mgr_i;

  always_comb begin
    w_sub_rdy   = 1'b0;
    w_sub_err   = 1'b0;
    w_sub_rdata = '0;
    for (int k = 0; k < NUM_SUB; k++) begin
      if (r_idx == IW'(k)) begin
        w_sub_rdy   = pready_sub_i[k];
        w_sub_err   = psuberr_sub_i[k];
        w_sub_rdata = prdata_sub_i[k*DW +: DW];
      end
    end
  end

`ifdef MSFTDVIP_APB_DEC_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  logic [CW-1:0] r_cnt;
  logic          w_xfer_exit;

  assign w_tout_hit  = (r_state == XFER) && psel_mgr_i && penable_mgr_i && !w_sub_rdy &&
                       (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_xfer_exit = !psel_mgr_i || (penable_mgr_i && w_sub_rdy) || w_tout_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_state != XFER || w_xfer_exit) begin
      r_cnt <= '0;
    end else if (penable_mgr_i && !w_sub_rdy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tout;
  assign w_tout_hit    = 1'b0;
  assign w_unused_tout = (TIMEOUT_CYCLES > 1);
`endif

  always_comb begin
    psel_sub_o    = '0;
    pready_mgr_o  = 1'b0;
    psuberr_mgr_o = 1'b0;
    prdata_mgr_o  = '0;
    w_err_evt     = ERR_NONE;
    case (r_state)
      IDLE: begin
        for (int k = 0; k < NUM_SUB; k++) begin
          psel_sub_o[k] = psel_mgr_i && w_hit_any && (w_idx == IW'(k));
        end
      end
      XFER: begin
        for (int k = 0; k < NUM_SUB; k++) begin
          psel_sub_o[k] = psel_mgr_i && (r_idx == IW'(k));
        end
        pready_mgr_o  = psel_mgr_i && w_sub_rdy;
        psuberr_mgr_o = psel_mgr_i && w_sub_err;
        prdata_mgr_o  = psel_mgr_i ? w_sub_rdata : '0;
        if (psel_mgr_i && penable_mgr_i && w_sub_rdy && w_sub_err) begin
          w_err_evt = ERR_SUB;
        end
      end
      DEFRSP: begin
        if (psel_mgr_i && penable_mgr_i) begin
          pready_mgr_o  = 1'b1;
          psuberr_mgr_o = 1'b1;
          w_err_evt     = ERR_DECODE;
        end
      end
      TOUT: begin
        pready_mgr_o  = 1'b1;
        psuberr_mgr_o = 1'b1;
        w_err_evt     = ERR_TIMEOUT;
      end
      default: ;
    endcase
    // Selects must read as idle for the whole reset window, even with the manager still selecting.
    if (rst_i) begin
      psel_sub_o = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (psel_mgr_i && !penable_mgr_i) begin
            r_idx   <= w_idx;
            r_addr  <= paddr_mgr_i;
            r_state <= w_hit_any ? XFER : DEFRSP;
          end
        end
        XFER: begin
          if (!psel_mgr_i) begin
            r_state <= IDLE;
          end else if (w_tout_hit) begin
            r_state <= TOUT;
          end else if (penable_mgr_i && w_sub_rdy) begin
            r_state <= IDLE;
          end
        end
        DEFRSP: begin
          if (!psel_mgr_i || penable_mgr_i) begin
            r_state <= IDLE;
          end
        end
        TOUT:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // First error wins; a clear in the same cycle as a new error lets the new one in.
      if (w_err_evt != ERR_NONE && (!r_err_valid || err_clr_i)) begin
        r_err_valid <= 1'b1;
        r_err_code  <= w_err_evt;
        r_err_addr  <= r_addr;
      end else if (err_clr_i) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  assign err_valid_o = r_err_valid;
  assign err_code_o  = r_err_code;
  assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_msftdvip_apb_decoder_n.sv
// Scoreboard bench for msftdvip_apb_decoder_n: directed scenarios then randomized transfers,
// expectations queued by the driver and checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_msftdvip_apb_decoder_n;

  localparam int NS = 3;
  localparam int TO = 8;
  localparam logic [31:0] M_BASE [NS] = '{32'h8F00_0600, 32'h8F00_0800, 32'h8F00_B000};
  localparam logic [31:0] M_MASK [NS] = '{32'hFFFF_FFC0, 32'hFFFF_FFC0, 32'hFFFF_F000};
  localparam logic [NS*32-1:0] P_BASE = {32'h8F00_B000, 32'h8F00_0800, 32'h8F00_0600};
  localparam logic [NS*32-1:0] P_MASK = {32'hFFFF_F000, 32'hFFFF_FFC0, 32'hFFFF_FFC0};
`ifdef MSFTDVIP_APB_DEC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0, err_clr = 1'b0;
  logic [31:0]    paddr = '0, pwdata = '0;
  logic [3:0]     pstrb = '0;
  logic [31:0]    prdata_mgr, paddr_sub, pwdata_sub, err_addr;
  logic           pready_mgr, psuberr_mgr, penable_sub, pwrite_sub, err_valid;
  logic [NS-1:0]  psel_sub;
  logic [3:0]     pstrb_sub;
  logic [1:0]     err_code;
  logic [NS*32-1:0] prdata_sub = '0;
  logic [NS-1:0]  pready_sub = '0, psuberr_sub = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  msftdvip_apb_decoder_n #(
    .NUM_SUB(NS), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32),
    .SUB_BASE(P_BASE), .SUB_MASK(P_MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .psel_mgr_i(psel), .penable_mgr_i(penable), .paddr_mgr_i(paddr),
    .pwdata_mgr_i(pwdata), .pwrite_mgr_i(pwrite), .pstrb_mgr_i(pstrb),
    .prdata_mgr_o(prdata_mgr), .pready_mgr_o(pready_mgr), .psuberr_mgr_o(psuberr_mgr),
    .psel_sub_o(psel_sub), .penable_sub_o(penable_sub), .paddr_sub_o(paddr_sub),
    .pwdata_sub_o(pwdata_sub), .pwrite_sub_o(pwrite_sub), .pstrb_sub_o(pstrb_sub),
    .prdata_sub_i(prdata_sub), .pready_sub_i(pready_sub), .psuberr_sub_i(psuberr_sub),
    .err_valid_o(err_valid), .err_code_o(err_code), .err_addr_o(err_addr),
    .err_clr_i(err_clr)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] rdata;
    logic        err;
    logic        resp;
    int          lat;
    logic        tout;
    logic [1:0]  code;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if ((a & M_MASK[k]) == (M_BASE[k] & M_MASK[k])) return k;
    end
    return -1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  exp_t        cur;
  bit          active = 0, done = 0;
  int          acc = 0;
  logic        m_ev = 0;
  logic [1:0]  m_code = 0;
  logic [31:0] m_addr = 0;

  always @(negedge clk_i) begin
    logic [1:0] comp_code;
    comp_code = 2'd0;
    if (rst_i) begin
      chk("rst_psel_sub", 64'(psel_sub), 64'd0);
      chk("rst_resp", 64'({pready_mgr, psuberr_mgr}), 64'd0);
      chk("rst_prdata", 64'(prdata_mgr), 64'd0);
      chk("rst_err", 64'({err_valid, err_code}), 64'd0);
      chk("rst_err_addr", 64'(err_addr), 64'd0);
      m_ev = 0; m_code = 0; m_addr = 0; active = 0; done = 0;
    end else begin
      chk("err_valid", 64'(err_valid), 64'(m_ev));
      chk("err_code", 64'(err_code), 64'(m_code));
      chk("err_addr", 64'(err_addr), 64'(m_addr));
      chk("bcast_dat", {pwdata_sub, paddr_sub}, {pwdata, paddr});
      chk("bcast_ctl", 64'({penable_sub, pwrite_sub, pstrb_sub}), 64'({penable, pwrite, pstrb}));
      if (psel && !penable) begin
        chk("prev_resp_seen", 64'(active && cur.resp && !done), 64'd0);
        chk("setup_expected", 64'(q.size() == 0), 64'd0);
        if (q.size() != 0) begin
          cur = q.pop_front();
          active = 1; done = 0; acc = 0;
          chk("setup_sel", 64'(psel_sub), 64'(cur.sel));
        end else begin
          active = 0;
        end
      end else if (psel && penable && active && !done) begin
        acc++;
        chk("acc_sel", 64'(psel_sub), 64'((cur.tout && acc == cur.lat) ? 3'b000 : cur.sel));
        chk("acc_ready", 64'(pready_mgr), 64'(cur.resp && acc == cur.lat));
        if (cur.resp && acc == cur.lat) begin
          chk("rsp_err", 64'(psuberr_mgr), 64'(cur.err));
          chk("rsp_rdata", 64'(prdata_mgr), 64'(cur.rdata));
          done = 1;
          comp_code = cur.code;
        end
      end else if (!psel) begin
        chk("idle_sel", 64'(psel_sub), 64'd0);
        chk("idle_ready", 64'(pready_mgr), 64'd0);
      end
      if (comp_code != 0 && (!m_ev || err_clr)) begin
        m_ev = 1; m_code = comp_code; m_addr = cur.addr;
      end else if (err_clr) begin
        m_ev = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic rand_subs();
    prdata_sub  = {$urandom, $urandom, $urandom};
    pready_sub  = 3'($urandom);
    psuberr_sub = 3'($urandom);
  endtask

  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      psel = 0; penable = 0; pready_sub = '0; psuberr_sub = '0;
      err_clr = clr && (i == 0);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input bit wr, input int waits, input bit serr,
                      input bit chg, input logic [31:0] chg_addr, input bit clr_done,
                      input bit drop, input logic [31:0] rd);
    exp_t e;
    int   tgt;
    tgt     = decode(a);
    e.addr  = a;
    e.sel   = (tgt >= 0) ? 3'(1 << tgt) : 3'b000;
    e.resp  = !drop;
    e.tout  = TO_EN && (tgt >= 0) && (waits >= TO);
    e.lat   = (tgt < 0) ? 1 : (e.tout ? TO + 1 : waits + 1);
    e.err   = (tgt < 0) || e.tout || serr;
    e.rdata = (tgt < 0 || e.tout) ? 32'h0 : rd;
    e.code  = (tgt < 0) ? 2'd1 : (e.tout ? 2'd2 : (serr ? 2'd3 : 2'd0));
    q.push_back(e);
    @(posedge clk_i); #1;
    psel = 1; penable = 0; paddr = a; pwrite = wr; pwdata = $urandom; pstrb = 4'($urandom);
    err_clr = 0;
    rand_subs();
    if (drop) begin
      @(posedge clk_i); #1;
      psel = 0; penable = 0; pready_sub = '0;
      return;
    end
    for (int i = 1; i <= e.lat; i++) begin
      @(posedge clk_i); #1;
      penable = 1;
      if (chg) paddr = chg_addr;
      rand_subs();
      if (tgt >= 0) begin
        pready_sub[tgt] = (i == e.lat);
        if (i == e.lat) begin
          psuberr_sub[tgt] = serr;
          prdata_sub[tgt*32 +: 32] = e.tout ? $urandom : rd;
        end
      end
      err_clr = clr_done && (i == e.lat);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    // Read from sub1 with two wait states.
    xfer(32'h8F00_0804, 0, 2, 0, 0, 0, 0, 0, 32'hA5A5_0001);
    idle(1, 0);
    // Unmapped write.
    xfer(32'h8F00_2000, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    idle(2, 0);
    // Stalled sub2 while an error is already held: first error must stay.
    xfer(32'h8F00_B010, 0, 12, 0, 0, 0, 0, 0, 32'h1234_5678);
    idle(1, 0);
    // Clear coinciding with a subordinate error.
    xfer(32'h8F00_0600, 0, 0, 1, 0, 0, 1, 0, 32'hDEAD_0600);
    idle(1, 1);
    // Stall with capture empty, then the last legal wait count.
    xfer(32'h8F00_B010, 0, 12, 0, 0, 0, 0, 0, 32'h0BAD_F00D);
    xfer(32'h8F00_B010, 0, 7, 0, 0, 0, 0, 0, 32'h7777_0007);
    idle(1, 1);
    // Back-to-back with address moving during the first access.
    xfer(32'h8F00_0600, 0, 2, 0, 1, 32'h8F00_B000, 0, 0, 32'h0000_0600);
    xfer(32'h8F00_B000, 1, 1, 0, 0, 0, 0, 0, 32'h0000_B000);
    // Manager abandons a transfer after setup: hit, then miss.
    xfer(32'h8F00_0810, 0, 1, 0, 0, 0, 0, 1, 32'h0);
    xfer(32'h1000_0000, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    idle(1, 0);
    xfer(32'h1000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    // Reset in the middle of an access phase.
    e.addr = 32'h8F00_0804; e.sel = 3'b010; e.resp = 0; e.lat = 100; e.tout = 0;
    e.err = 0; e.rdata = 0; e.code = 0;
    q.push_back(e);
    @(posedge clk_i); #1;
    psel = 1; penable = 0; paddr = 32'h8F00_0804; pready_sub = '0;
    @(posedge clk_i); #1;
    penable = 1;
    @(posedge clk_i); #1;
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0; psel = 0; penable = 0;
    idle(1, 0);
    xfer(32'h8F00_0804, 0, 1, 0, 0, 0, 0, 0, 32'hC0DE_0804);
    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      int          kind;
      int          waits;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      if (kind == 0) a = $urandom;
      else a = (M_BASE[kind-1] & M_MASK[kind-1]) | ($urandom & ~M_MASK[kind-1]);
      waits = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
      xfer(a, 1'($urandom), waits, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0, $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2), $urandom_range(0, 3) == 0);
    end
    idle(3, 0);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("last_resp_seen", 64'(active && cur.resp && !done), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
